popcount_serial: RTL and testbench
==================================

// Module: popcount_serial
// PURPOSE
// - Bit-serial population-count stage: accepts one W-bit word over a valid/ready handshake.
// - Scans the word LSB-first, one bit per clock, and presents the count of ones on a
//   valid/ready output handshake.
// - Produces the count values consumed by the downstream popcount result path.
// - With default W=4 the count is 3 bits wide, matching that path's 3-bit result.
// PARAMETERS
// W   4                 input word width in bits; legal range W >= 1
// CW  $clog2(W+1)       count width; derived, do not override
// PORTS
// clk        input   1    single clock, all state updates on posedge
// rst_n      input   1    asynchronous active-low reset
// in_valid   input   1    in_data is valid this cycle
// in_ready   output  1    block can accept a word this cycle
// in_data    input   W    word to be counted
// out_valid  output  1    out_count holds a finished result
// out_ready  input   1    downstream accepts out_count this cycle
// out_count  output  CW   number of 1 bits in the last accepted word
// busy       output  1    1 in SHIFT or DONE state
// BEHAVIOUR
// - Reset (rst_n low, asynchronous): state=IDLE; shreg, cnt, idx, out_count cleared to 0.
//   While rst_n is low: out_valid=0, busy=0, in_ready=0.
// - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE:
//   - in_ready=1.
//   - On an edge with in_valid&&in_ready: shreg<=in_data, cnt<=0, idx<=0, go to SHIFT.
// - SHIFT:
//   - in_ready=0.
//   - Each edge: cnt<=cnt+shreg[0], shreg<=shreg>>1, idx<=idx+1.
//   - On the edge where idx==W-1: out_count<=cnt+shreg[0], go to DONE.
//   - Fixed W cycles, independent of data; no early exit on shreg==0.
// - DONE:
//   - out_valid=1, in_ready=0.
//   - out_count is stable until the handshake; out_valid never drops without out_ready.
//   - On an edge with out_ready=1: go to IDLE.
// - Handshake outputs: out_valid and in_ready are pure decodes of state (gated by rst_n).
//   No combinational path from in_valid or out_ready to any output.
// - Latency: accept at edge T -> out_valid=1 after edge T+W.
// - Throughput: one word per W+2 cycles minimum (IDLE and DONE each cost 1 cycle).
// - Width: cnt and out_count are CW bits. All-ones gives W (W=4 -> 3'd4), with no overflow.
//   W=1 gives CW=1 and a single SHIFT cycle.
// - in_data changing while not accepted is ignored; only the captured shreg is counted.
// - out_ready high outside DONE has no effect.
// - Reset mid-SHIFT or mid-DONE aborts immediately; the result is discarded, never emitted.
// - Between results, out_count holds the last value (0 after reset).
// TESTING
// 1. W=4, in_data=4'b1011, out_ready=1 -> accepted at edge T; out_valid=1 after edge T+4;
//    out_count=3; state back to IDLE one cycle later.
// 2. W=4, in_data=4'b0000, then 4'b1111 back-to-back (in_valid held) ->
//    results 0 then 4 (3'b100); second accept occurs exactly 6 cycles after the first.
// 3. in_data=4'b0110, out_ready=0 for 5 cycles after out_valid rises ->
//    out_valid stays 1 and out_count=2 stays stable; in_ready=0 throughout;
//    exactly one handshake once out_ready=1.
// 4. Assert rst_n=0 asynchronously (mid-clock) during the 2nd SHIFT cycle of 4'b1111 ->
//    out_valid/busy/out_count go to 0 without a clock edge; after release, no result for
//    that word; next word 4'b0001 yields 1.
// 5. in_valid pulsed during SHIFT/DONE with different data ->
//    ignored (in_ready=0); only the originally accepted word's count is produced.
// 6. Param sweep W=1 (data 1 -> 1, latency 1) and W=8 (8'hFF -> 8, 8'hA5 -> 4, latency 8).

Source files
------------

// File: rtl/popcount_serial.sv
// popcount_serial: counts the ones in a W-bit word one bit per clock.
// A word is taken over a valid/ready input handshake and scanned LSB-first.
// The count is then held on a valid/ready output handshake until downstream takes it.
module popcount_serial #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    // idx must hold 0..W-1. It is kept at least 1 bit wide so that W=1 still works.
    localparam int            IW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          accept;
    logic          last_bit;
    logic [CW-1:0] cnt_sum;

    assign accept   = in_valid && (state == IDLE);
    assign last_bit = (idx == LAST);
    assign cnt_sum  = cnt + CW'(shreg[0]);

    // State register: the asynchronous reset returns the FSM to IDLE at once.
    // NOTE: clocked state uses non-blocking (<=) assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake decode. The outputs depend only on state, never on in_valid or out_ready.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, then spend exactly W cycles shifting and accumulating.
    // The result is published only on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            idx       <= '0;
            out_count <= '0;
        end else begin
            if (accept) begin
                shreg <= in_data;
                cnt   <= '0;
                idx   <= '0;
            end else if (state == SHIFT) begin
                cnt   <= cnt_sum;
                shreg <= shreg >> 1;
                idx   <= idx + IW'(1);
                if (last_bit) begin
                    out_count <= cnt_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_serial.sv
// tb_popcount_serial: self-checking bench for popcount_serial at W=1, W=4 and W=8.
// Each instance shares one clock and one reset.
module tb_popcount_serial;

    logic clk;
    logic rst_n;

    // W=1 instance
    logic       iv1, ir1, ov1, or1, busy1;
    logic [0:0] id1;
    logic [0:0] oc1;
    // W=4 instance
    logic       iv4, ir4, ov4, or4, busy4;
    logic [3:0] id4;
    logic [2:0] oc4;
    // W=8 instance
    logic       iv8, ir8, ov8, or8, busy8;
    logic [7:0] id8;
    logic [3:0] oc8;

    popcount_serial #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_count(oc1), .busy(busy1)
    );
    popcount_serial #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_count(oc4), .busy(busy4)
    );
    popcount_serial #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_count(oc8), .busy(busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$];   // cycle numbers of W=4 input handshakes
    int res_q[$];   // W=4 output handshake counts

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (iv4 && ir4) acc_q.push_back(cyc);
            if (ov4 && or4) res_q.push_back(int'(oc4));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: ones in the low w bits of d, counted independently of any FSM.
    function automatic int ref_pop(input logic [7:0] d, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) n += int'(d[i]);
        return n;
    endfunction

    task automatic drive(input int which, input logic v, input logic [7:0] d, input logic r);
        case (which)
            1: begin iv1 = v; id1 = d[0:0]; or1 = r; end
            4: begin iv4 = v; id4 = d[3:0]; or4 = r; end
            default: begin iv8 = v; id8 = d; or8 = r; end
        endcase
    endtask

    function automatic logic f_ir(input int which);
        case (which)
            1: return ir1;
            4: return ir4;
            default: return ir8;
        endcase
    endfunction

    function automatic logic f_ov(input int which);
        case (which)
            1: return ov1;
            4: return ov4;
            default: return ov8;
        endcase
    endfunction

    function automatic logic f_busy(input int which);
        case (which)
            1: return busy1;
            4: return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic int f_oc(input int which);
        case (which)
            1: return int'(oc1);
            4: return int'(oc4);
            default: return int'(oc8);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete word on instance `which` (which also gives W).
    // Latency, count, stall stability and the single-handshake return to IDLE are checked.
    task automatic xfer(input int which, input logic [7:0] data, input int stall, input int exp_cnt);
        int   k;
        int   lat;
        logic acc;
        logic stable;
        drive(which, 1'b1, data, stall == 0);
        k = 0;
        acc = 1'b0;
        while (!acc && k < 20) begin
            acc = f_ir(which);
            tick();
            k++;
        end
        check($sformatf("accept w%0d", which), int'(acc), 1);
        if (!acc) return;
        // Scrambled data on the idle bus must not leak into the count.
        drive(which, 1'b0, ~data, stall == 0);
        check($sformatf("busy w%0d", which), int'(f_busy(which)), 1);
        lat = 0;
        while (!f_ov(which) && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("latency w%0d", which), lat, which);
        check($sformatf("count w%0d d=%0h", which, data), f_oc(which), exp_cnt);
        if (stall > 0) begin
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (!f_ov(which) || f_ir(which) || f_oc(which) != exp_cnt) stable = 1'b0;
            end
            check($sformatf("stall hold w%0d", which), int'(stable), 1);
            drive(which, 1'b0, ~data, 1'b1);
        end
        tick();
        check($sformatf("released w%0d", which), int'(f_ov(which)), 0);
        check($sformatf("idle ready w%0d", which), int'(f_ir(which)), 1);
        check($sformatf("count held w%0d", which), f_oc(which), exp_cnt);
    endtask

    typedef struct {
        logic [7:0] data;
        int         stall;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0;
        int nr;
        int k;
        logic ok;
        logic [7:0] d;

        vecs[0] = '{8'h0B, 0, 3};   // 4'b1011
        vecs[1] = '{8'h06, 5, 2};   // 4'b0110 with 5 stall cycles
        vecs[2] = '{8'h00, 0, 0};
        vecs[3] = '{8'h0F, 1, 4};   // all ones, no overflow
        vecs[4] = '{8'h08, 0, 1};
        vecs[5] = '{8'h07, 2, 3};

        drive(1, 1'b0, 8'h00, 1'b0);
        drive(4, 1'b0, 8'h00, 1'b0);
        drive(8, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #23;
        check("reset in_ready", int'(ir4), 0);
        check("reset out_valid", int'(ov4), 0);
        check("reset busy", int'(busy4), 0);
        check("reset out_count", int'(oc4), 0);
        rst_n = 1'b1;
        tick();
        check("post reset in_ready", int'(ir4), 1);

        // Table-driven vectors on W=4
        for (int i = 0; i < 6; i++) xfer(4, vecs[i].data, vecs[i].stall, vecs[i].exp_cnt);

        // Back-to-back words with in_valid held: 0000 then 1111, accepted 6 cycles apart
        n0 = acc_q.size();
        nr = res_q.size();
        drive(4, 1'b1, 8'h00, 1'b1);
        k = 0;
        while (acc_q.size() < n0 + 1 && k < 20) begin tick(); k++; end
        drive(4, 1'b1, 8'h0F, 1'b1);
        k = 0;
        while (acc_q.size() < n0 + 2 && k < 20) begin tick(); k++; end
        drive(4, 1'b0, 8'h00, 1'b1);
        check("b2b accepts", acc_q.size() - n0, 2);
        if (acc_q.size() >= n0 + 2) check("b2b spacing", acc_q[n0 + 1] - acc_q[n0], 6);
        k = 0;
        while (res_q.size() < nr + 2 && k < 20) begin tick(); k++; end
        check("b2b results", res_q.size() - nr, 2);
        if (res_q.size() >= nr + 2) begin
            check("b2b first", res_q[nr], 0);
            check("b2b second", res_q[nr + 1], 4);
        end
        tick();

        // Input pulses during SHIFT and DONE must be ignored
        n0 = acc_q.size();
        nr = res_q.size();
        drive(4, 1'b1, 8'h01, 1'b0);
        k = 0;
        while (acc_q.size() < n0 + 1 && k < 20) begin tick(); k++; end
        ok = 1'b1;
        k = 0;
        while (!ov4 && k < 20) begin
            drive(4, 1'b1, 8'($urandom_range(2, 15)), 1'b0);
            if (ir4) ok = 1'b0;
            tick();
            k++;
        end
        for (int s = 0; s < 2; s++) begin
            if (ir4 || !ov4) ok = 1'b0;
            tick();
        end
        check("ignore no ready", int'(ok), 1);
        drive(4, 1'b0, 8'h00, 1'b1);
        tick();
        check("ignore accepts", acc_q.size() - n0, 1);
        check("ignore results", res_q.size() - nr, 1);
        if (res_q.size() > nr) check("ignore count", res_q[nr], 1);

        // Asynchronous reset mid-clock during the second SHIFT cycle of 1111
        xfer(4, 8'h07, 0, 3);
        nr = res_q.size();
        n0 = acc_q.size();
        drive(4, 1'b1, 8'h0F, 1'b1);
        k = 0;
        while (acc_q.size() < n0 + 1 && k < 20) begin tick(); k++; end
        drive(4, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #4;
        check("pre-abort busy", int'(busy4), 1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", int'(ov4), 0);
        check("abort busy", int'(busy4), 0);
        check("abort out_count", int'(oc4), 0);
        check("abort in_ready", int'(ir4), 0);
        #10;
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) tick();
        check("abort no result", res_q.size() - nr, 0);
        check("abort out_valid after", int'(ov4), 0);
        xfer(4, 8'h01, 0, 1);

        // Randomized words against the reference model
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom_range(0, 15));
            xfer(4, d, int'($urandom_range(0, 2)), ref_pop(d, 4));
        end
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            xfer(8, d, int'($urandom_range(0, 2)), ref_pop(d, 8));
        end

        // Width corners
        xfer(1, 8'h01, 0, 1);
        xfer(1, 8'h00, 1, 0);
        xfer(8, 8'hFF, 0, 8);
        xfer(8, 8'hA5, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
